// File: rtl/dilithium_io_pkg.sv
// Shared types and field sizes for the Dilithium input framer.
// Field sizes are per security level; the byte-keep port exists only with DILITHIUM_IOSEQ_KEEP_EN.
package dilithium_io_pkg;

    typedef enum logic [3:0] {
        SEED_RHO, SEED_K, SEED_TR, SEED_C,
        S1, S2, T0, T1, Z, H, MSG_LEN, MSG
    } field_id_t;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [1:0] MODE_KEYGEN = 2'b00;
    localparam logic [1:0] MODE_SIGN   = 2'b10;
    localparam logic [1:0] MODE_VERIFY = 2'b01;

    localparam int CNT_W  = 12;
    localparam int IDX_W  = 3;
    localparam int BITS_W = 16;

    localparam int unsigned SEED_BITS = 256;
    localparam int unsigned S1_L2 = 3072,  S1_L3 = 5120,  S1_L5 = 5376;
    localparam int unsigned S2_L2 = 3072,  S2_L3 = 6144,  S2_L5 = 6144;
    localparam int unsigned T1_L2 = 10240, T1_L3 = 15360, T1_L5 = 20480;
    localparam int unsigned T0_L2 = 13312, T0_L3 = 19968, T0_L5 = 26624;
    localparam int unsigned Z_L2  = 18432, Z_L3  = 25600, Z_L5  = 35840;
    localparam int unsigned H_L2  = 672,   H_L3  = 488,   H_L5  = 664;

    function automatic int unsigned words(input int unsigned bits,
                                          input int unsigned w);
        return (bits + w - 1) / w;
    endfunction

    function automatic logic legal_cfg(input logic [1:0] mode,
                                       input logic [2:0] lvl);
        return (mode != 2'b11) &&
               (lvl == 3'd2 || lvl == 3'd3 || lvl == 3'd5);
    endfunction

    function automatic int unsigned by_level(input logic [2:0] lvl,
                                             input int unsigned l2,
                                             input int unsigned l3,
                                             input int unsigned l5);
        case (lvl)
            3'd2:    return l2;
            3'd3:    return l3;
            default: return l5;
        endcase
    endfunction

    // MSG size comes from the stream, so the table reports 0 for it
    function automatic int unsigned field_bits(input field_id_t f,
                                               input logic [2:0] lvl,
                                               input int unsigned w);
        case (f)
            S1:      return by_level(lvl, S1_L2, S1_L3, S1_L5);
            S2:      return by_level(lvl, S2_L2, S2_L3, S2_L5);
            T1:      return by_level(lvl, T1_L2, T1_L3, T1_L5);
            T0:      return by_level(lvl, T0_L2, T0_L3, T0_L5);
            Z:       return by_level(lvl, Z_L2, Z_L3, Z_L5);
            H:       return by_level(lvl, H_L2, H_L3, H_L5);
            MSG_LEN: return w;
            MSG:     return 0;
            default: return SEED_BITS;
        endcase
    endfunction

endpackage

// File: rtl/dilithium_io_schedule.sv
// Field schedule ROM: (mode, level, index) -> field id, word count, last-field flag.
// With DILITHIUM_IOSEQ_KEEP_EN the field bit size is exported for keep masks.
module dilithium_io_schedule
    import dilithium_io_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [1:0]       mode,
    input  logic [2:0]       sec_level,
    input  logic [IDX_W-1:0] idx,
    output field_id_t        field,
    output logic [CNT_W-1:0] count,
    output logic             last_field
`ifdef DILITHIUM_IOSEQ_KEEP_EN
    ,
    output logic [BITS_W-1:0] bits
`endif
);

    int unsigned fbits;

    always_comb begin
        field      = SEED_RHO;
        last_field = 1'b0;
        unique case (mode)
            MODE_SIGN: begin
                unique case (idx)
                    3'd0: field = SEED_RHO;
                    3'd1: field = SEED_K;
                    3'd2: field = SEED_TR;
                    3'd3: field = S1;
                    3'd4: field = S2;
                    3'd5: field = T0;
                    3'd6: field = MSG_LEN;
                    default: begin
                        field      = MSG;
                        last_field = 1'b1;
                    end
                endcase
            end
            MODE_VERIFY: begin
                unique case (idx)
                    3'd0: field = SEED_RHO;
                    3'd1: field = T1;
                    3'd2: field = SEED_C;
                    3'd3: field = Z;
                    3'd4: field = H;
                    3'd5: field = MSG_LEN;
                    default: begin
                        field      = MSG;
                        last_field = 1'b1;
                    end
                endcase
            end
            default: last_field = 1'b1;
        endcase
    end

    assign fbits = field_bits(field, sec_level, W);
    assign count = CNT_W'(words(fbits, W));

`ifdef DILITHIUM_IOSEQ_KEEP_EN
    assign bits = BITS_W'(fbits);
`endif

endmodule

// File: rtl/dilithium_io_sequencer.sv
// Dilithium host input framer: tags pass-through words with field, last and end-of-op flags.
// Define DILITHIUM_IOSEQ_KEEP_EN to add the out_keep byte mask port.
module dilithium_io_sequencer
    import dilithium_io_pkg::*;
#(
    parameter int W            = 64,
    parameter int MSG_MAX_BITS = 26400,
    parameter int MSG_LEN_SIZE = $clog2(MSG_MAX_BITS) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [2:0]              sec_level,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic [3:0]              out_field,
    output logic                    out_last,
    output logic                    out_eop,
    output logic [MSG_LEN_SIZE-1:0] msg_len,
    output logic                    busy,
    output logic                    done,
    output logic                    error
`ifdef DILITHIUM_IOSEQ_KEEP_EN
    ,
    output logic [W/8-1:0]          out_keep
`endif
);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic [2:0]              lvl_q, lvl_d;
    logic                    err_q, err_d;
    logic [MSG_LEN_SIZE-1:0] len_q, len_d;

    field_id_t               sched_field;
    logic [CNT_W-1:0]        sched_count;
    logic                    sched_last;
    logic                    streaming, xfer, is_len;
    logic                    len_zero, len_bad, last_word, eop;
    logic [CNT_W-1:0]        msg_words, total;
    logic [MSG_LEN_SIZE-1:0] len_in;

`ifdef DILITHIUM_IOSEQ_KEEP_EN
    logic [BITS_W-1:0]       sched_bits;
`endif

    dilithium_io_schedule #(.W(W)) u_sched (
        .mode       (mode_q),
        .sec_level  (lvl_q),
        .idx        (idx_q),
        .field      (sched_field),
        .count      (sched_count),
        .last_field (sched_last)
`ifdef DILITHIUM_IOSEQ_KEEP_EN
        ,
        .bits       (sched_bits)
`endif
    );

    // cnt_q counts words already sent in the current field
    assign streaming = (state_q == STREAM);
    assign xfer      = streaming && in_valid && out_ready;
    assign len_in    = in_data[MSG_LEN_SIZE-1:0];
    assign len_zero  = (len_in == '0);
    assign len_bad   = (len_in > MSG_LEN_SIZE'(MSG_MAX_BITS));
    assign is_len    = (sched_field == MSG_LEN);
    assign msg_words = CNT_W'(words(32'(len_q), W));
    assign total     = (sched_field == MSG) ? msg_words : sched_count;
    assign last_word = streaming && (cnt_q == total - CNT_W'(1));
    assign eop       = last_word &&
                       (sched_last || (is_len && (len_zero || len_bad)));

    assign out_valid = streaming && in_valid;
    assign in_ready  = streaming && out_ready;
    assign out_data  = streaming ? in_data : '0;
    assign out_field = streaming ? sched_field : SEED_RHO;
    assign out_last  = last_word;
    assign out_eop   = eop;
    assign msg_len   = len_q;
    assign busy      = streaming;
    assign done      = (state_q == DONE);
    assign error     = err_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        lvl_d   = lvl_q;
        err_d   = err_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (legal_cfg(mode, sec_level)) begin
                        mode_d  = mode;
                        lvl_d   = sec_level;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (is_len) len_d = len_in;
                    if (!last_word) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (is_len && len_bad) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (eop) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = '0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            lvl_q   <= '0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            lvl_q   <= lvl_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

`ifdef DILITHIUM_IOSEQ_KEEP_EN
    localparam int KW = W / 8;
    int unsigned cur_bits, rem, nbytes;

    // Only a field's final word can be partial
    always_comb begin
        cur_bits = (sched_field == MSG) ? 32'(len_q) : 32'(sched_bits);
        rem      = cur_bits % W;
        nbytes   = (rem + 7) / 8;
        out_keep = '0;
        if (streaming) begin
            out_keep = '1;
            if (last_word && rem != 0)
                out_keep = KW'((32'd1 << nbytes) - 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_dilithium_io_sequencer.sv
// Randomized bench for dilithium_io_sequencer against a queue-based stream model.
// Keep-mask checks are active when DILITHIUM_IOSEQ_KEEP_EN is defined.
module tb_dilithium_io_sequencer;
    import dilithium_io_pkg::*;

    localparam int W    = 64;
    localparam int KW   = W / 8;
    localparam int MMAX = 26400;
    localparam int LS   = $clog2(MMAX) + 1;

    logic          clk, rst_n, start;
    logic [1:0]    mode;
    logic [2:0]    sec_level;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [3:0]    out_field;
    logic          out_last, out_eop, busy, done, error;
    logic [LS-1:0] msg_len;
`ifdef DILITHIUM_IOSEQ_KEEP_EN
    logic [KW-1:0] out_keep;
    logic [KW-1:0] h_keep;
`endif

    dilithium_io_sequencer #(.W(W), .MSG_MAX_BITS(MMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .sec_level(sec_level), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_field(out_field), .out_last(out_last),
        .out_eop(out_eop), .msg_len(msg_len), .busy(busy), .done(done),
        .error(error)
`ifdef DILITHIUM_IOSEQ_KEEP_EN
        , .out_keep(out_keep)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [3:0]    f;
        logic          last;
        logic          eop;
        logic [KW-1:0] keep;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] src_q[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           xfers;
    int           fcount[16];
    logic [3:0]   eop_field;
    bit           mon_en = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int unsigned lv(input int lvl, input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
        return (lvl == 2) ? a : (lvl == 3) ? b : c;
    endfunction

    function automatic int unsigned spec_bits(input field_id_t f,
                                              input int lvl);
        case (f)
            S1:      return lv(lvl, 3072, 5120, 5376);
            S2:      return lv(lvl, 3072, 6144, 6144);
            T1:      return lv(lvl, 10240, 15360, 20480);
            T0:      return lv(lvl, 13312, 19968, 26624);
            Z:       return lv(lvl, 18432, 25600, 35840);
            H:       return lv(lvl, 672, 488, 664);
            default: return 256;
        endcase
    endfunction

    task automatic add_field(input field_id_t f, input int unsigned bits,
                             input bit fixed, input logic [W-1:0] fval);
        int unsigned n   = (bits + W - 1) / W;
        int unsigned rem = bits % W;
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.data = fixed ? fval : {$urandom, $urandom};
            e.f    = f;
            e.last = (i == n - 1);
            e.eop  = 1'b0;
            e.keep = '1;
            if (i == n - 1 && rem != 0)
                e.keep = KW'((64'd1 << ((rem + 7) / 8)) - 64'd1);
            exp_q.push_back(e);
            src_q.push_back(e.data);
        end
    endtask

    task automatic build(input logic [1:0] m, input int lvl,
                         input int unsigned len);
        field_id_t sched[$];
        logic [W-1:0] v;
        exp_t e;
        exp_q.delete();
        src_q.delete();
        if (m == 2'b10)
            sched = '{SEED_RHO, SEED_K, SEED_TR, S1, S2, T0, MSG_LEN, MSG};
        else if (m == 2'b01)
            sched = '{SEED_RHO, T1, SEED_C, Z, H, MSG_LEN, MSG};
        else
            sched = '{SEED_RHO};
        foreach (sched[i]) begin
            if (sched[i] == MSG_LEN) begin
                v = {$urandom, $urandom};
                v[LS-1:0] = LS'(len);
                add_field(MSG_LEN, W, 1'b1, v);
                if (len == 0 || len > MMAX) break;
            end else if (sched[i] == MSG) begin
                add_field(MSG, len, 1'b0, '0);
            end else begin
                add_field(sched[i], spec_bits(sched[i], lvl), 1'b0, '0);
            end
        end
        e = exp_q.pop_back();
        e.eop = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        #2;
        if (mon_en && busy) begin
            chk("valid_passthru", out_valid, in_valid);
            chk("ready_passthru", in_ready, out_ready);
            if (in_valid && in_ready) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("data", out_data, mon_e.data);
                    chk("field", out_field, mon_e.f);
                    chk("last", out_last, mon_e.last);
                    chk("eop", out_eop, mon_e.eop);
`ifdef DILITHIUM_IOSEQ_KEEP_EN
                    chk("keep", out_keep, mon_e.keep);
`endif
                end
`ifdef DILITHIUM_IOSEQ_KEEP_EN
                if (out_field == H && out_last) h_keep = out_keep;
`endif
                fcount[out_field]++;
                xfers++;
                if (out_eop) eop_field = out_field;
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {out_valid, in_ready, out_last, out_eop,
                            busy, done, error, out_field}, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_len"}, msg_len, 0);
    endtask

    task automatic run_op(input logic [1:0] m, input int lvl,
                          input int unsigned len, input bit bp,
                          input int abort_at);
        int cyc = 0;
        bit exp_err = (m != 2'b00) && (len > MMAX);
        build(m, lvl, len);
        xfers = 0;
        eop_field = 4'hF;
        foreach (fcount[i]) fcount[i] = 0;
        @(negedge clk);
        start = 1; mode = m; sec_level = 3'(lvl);
        in_valid = 0; out_ready = 0;
        @(negedge clk);
        start = 0;
        mon_en = 1;
        chk("busy_after_start", busy, 1);
        chk("error_cleared", error, 0);
        while (src_q.size() > 0 && cyc < 20000) begin
            in_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = src_q[0];
            start     = ($urandom_range(0, 7) == 0);
            mode      = 2'($urandom);
            sec_level = 3'($urandom);
            #3;
            if (in_valid && in_ready) void'(src_q.pop_front());
            if (abort_at > 0 && xfers >= abort_at) begin
                chk("abort_in_t1", fcount[T1] > 0 && fcount[Z] == 0, 1);
                #1 rst_n = 0;
                #1 check_zero("async_reset");
                mon_en = 0;
                start = 0; in_valid = 0;
                @(negedge clk);
                rst_n = 1;
                exp_q.delete();
                src_q.delete();
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; in_valid = 0; out_ready = 1;
        chk("op_within_budget", cyc < 20000, 1);
        if (exp_err) begin
            chk("err_flag", error, 1);
            chk("err_busy", busy, 0);
            chk("err_no_done", done, 0);
        end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_no_err", error, 0);
        end
        chk("all_words_seen", exp_q.size(), 0);
        chk("ready_low_after", in_ready, 0);
        mon_en = 0;
        @(negedge clk);
        chk("back_to_idle", {done, busy, in_ready, out_valid}, 0);
    endtask

    initial begin
        int r, lvl, m;
        int unsigned len;
        rst_n = 0; start = 0; mode = 0; sec_level = 0;
        in_valid = 1; out_ready = 1; in_data = '1;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1;
        in_valid = 0;

        run_op(2'b00, 2, 0, 0, 0);
        chk("kg_words", xfers, 4);
        chk("kg_seed", fcount[SEED_RHO], 4);
        chk("kg_eop_field", eop_field, SEED_RHO);

        run_op(2'b01, 2, 64, 0, 0);
        chk("vf_rho", fcount[SEED_RHO], 4);
        chk("vf_t1", fcount[T1], 160);
        chk("vf_c", fcount[SEED_C], 4);
        chk("vf_z", fcount[Z], 288);
        chk("vf_h", fcount[H], 11);
        chk("vf_len", fcount[MSG_LEN], 1);
        chk("vf_msg", fcount[MSG], 1);
        chk("vf_total", xfers, 469);
        chk("vf_msg_len", msg_len, 64);

        run_op(2'b10, 5, 1000, 1, 0);
        chk("sg_s1", fcount[S1], 84);
        chk("sg_s2", fcount[S2], 96);
        chk("sg_t0", fcount[T0], 416);
        chk("sg_msg", fcount[MSG], 16);

        run_op(2'b10, 2, 0, 1, 0);
        chk("len0_no_msg", fcount[MSG], 0);
        chk("len0_eop_field", eop_field, MSG_LEN);

        run_op(2'b10, 3, 30000, 1, 0);
        chk("bad_len_captured", msg_len, 30000);
        chk("bad_len_no_msg", fcount[MSG], 0);

        @(negedge clk);
        start = 1; mode = 2'b11; sec_level = 3'd2;
        @(negedge clk);
        start = 0;
        chk("ill_mode_err", error, 1);
        chk("ill_mode_busy", {busy, in_ready}, 0);
        run_op(2'b00, 3, 0, 0, 0);
        @(negedge clk);
        start = 1; mode = 2'b00; sec_level = 3'd4;
        @(negedge clk);
        start = 0;
        chk("ill_lvl_err", error, 1);
        chk("ill_lvl_busy", {busy, in_ready}, 0);

        run_op(2'b01, 3, 512, 1, 50);
        run_op(2'b00, 5, 0, 0, 0);
        chk("post_reset_kg", xfers, 4);

`ifdef DILITHIUM_IOSEQ_KEEP_EN
        run_op(2'b01, 3, 64, 0, 0);
        chk("keep_h_l3", h_keep, 8'h1F);
        run_op(2'b01, 2, 100, 1, 0);
        chk("keep_h_l2", h_keep, 8'h0F);
`endif

        for (int k = 0; k < 6; k++) begin
            r   = $urandom_range(0, 2);
            m   = (r == 0) ? 0 : (r == 1) ? 2 : 1;
            r   = $urandom_range(0, 2);
            lvl = (r == 0) ? 2 : (r == 1) ? 3 : 5;
            r   = $urandom_range(0, 9);
            len = (r == 0) ? MMAX : (r == 1) ? MMAX + 1 :
                  (r == 2) ? 0 : $urandom_range(1, MMAX);
            run_op(2'(m), lvl, len, 1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
